// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types: RV32I opcode/control-word types, immediates and source-usage helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3;

  typedef struct packed {
    rv32i_opcode  opcode;
    alu_ops       aluop;
    branch_funct3 cmpop;
    logic [4:0]   rd;
    logic         load_regfile;
    logic         mem_read;
    logic         mem_write;
    logic         alu_mux1_sel;
    logic [2:0]   alu_mux2_sel;
    logic [3:0]   regfile_mux_sel;
    logic         cmp_mux_sel;
    logic [3:0]   mem_wmask;
  } rv32i_control_word;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] u;
    logic [31:0] j;
  } rv32i_imm_bundle;

  // addi x0,x0,0 with every side-effect enable cleared
  localparam rv32i_control_word CWORD_NOP = '{
    opcode:          op_imm,
    aluop:           alu_add,
    cmpop:           beq,
    rd:              5'd0,
    load_regfile:    1'b0,
    mem_read:        1'b0,
    mem_write:       1'b0,
    alu_mux1_sel:    1'b0,
    alu_mux2_sel:    3'd0,
    regfile_mux_sel: 4'd0,
    cmp_mux_sel:     1'b0,
    mem_wmask:       4'd0
  };

  function automatic logic uses_rs1(input rv32i_opcode op);
    return op inside {op_jalr, op_br, op_load, op_store, op_imm, op_reg};
  endfunction

  function automatic logic uses_rs2(input rv32i_opcode op);
    return op inside {op_br, op_store, op_reg};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect: combinational load-use detection between the EX slot and ID. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_detect
  import rv32i_types::*;
(
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_load_regfile,
  input  logic [4:0]  ex_rd,
  input  logic        id_valid,
  input  rv32i_opcode id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        load_use
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // x0 is never written, so a load targeting it cannot create a dependency
  assign ex_is_load = ex_valid & ex_mem_read & ex_load_regfile & (ex_rd != 5'd0);
  assign rs1_match  = uses_rs1(id_opcode) & (id_rs1 == ex_rd);
  assign rs2_match  = uses_rs2(id_opcode) & (id_rs2 == ex_rd);
  assign load_use   = ex_is_load & id_valid & (rs1_match | rs2_match);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage: ID/EX pipeline register with load-use/flush bubbles and hazard counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_stage
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  rv32i_control_word id_cword,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  rv32i_imm_bundle   id_imm,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_valid,
  output rv32i_control_word ex_cword,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output rv32i_imm_bundle   ex_imm,
  output logic              hold_if_id,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic load_use;

  hazard_detect u_hazard_detect (
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_cword.mem_read),
    .ex_load_regfile (ex_cword.load_regfile),
    .ex_rd           (ex_cword.rd),
    .id_valid        (id_valid),
    .id_opcode       (id_cword.opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .load_use        (load_use)
  );

  // a flush squashes the dependent instruction, so IF/ID must not freeze for it
  assign hold_if_id = mem_stall | (load_use & ~flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_cword     <= CWORD_NOP;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      load_use_cnt <= '0;
      flush_cnt    <= '0;
    end else if (!mem_stall) begin
      // data fields follow ID unconditionally; validity and control decide what EX executes
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      if (flush) begin
        ex_valid <= 1'b0;
        ex_cword <= CWORD_NOP;
        if (id_valid && flush_cnt != CNT_MAX) begin
          flush_cnt <= flush_cnt + CNT_ONE;
        end
      end else if (load_use) begin
        ex_valid <= 1'b0;
        ex_cword <= CWORD_NOP;
        if (load_use_cnt != CNT_MAX) begin
          load_use_cnt <= load_use_cnt + CNT_ONE;
        end
      end else begin
        ex_valid <= id_valid;
        ex_cword <= id_valid ? id_cword : CWORD_NOP;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage: directed table, corner sequences and randomized model check for id_ex_stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;
  import rv32i_types::*;

  localparam int CW = 2;
  localparam int CMAX = 3;

  logic              clk;
  logic              rst;
  logic              id_valid;
  rv32i_control_word id_cword;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [31:0]       id_rs1_data;
  logic [31:0]       id_rs2_data;
  rv32i_imm_bundle   id_imm;
  logic              mem_stall;
  logic              flush;
  logic              ex_valid;
  rv32i_control_word ex_cword;
  logic [31:0]       ex_pc;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [31:0]       ex_rs1_data;
  logic [31:0]       ex_rs2_data;
  rv32i_imm_bundle   ex_imm;
  logic              hold_if_id;
  logic [CW-1:0]     load_use_cnt;
  logic [CW-1:0]     flush_cnt;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cword(id_cword), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .mem_stall(mem_stall), .flush(flush), .ex_valid(ex_valid),
    .ex_cword(ex_cword), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .hold_if_id(hold_if_id), .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model of the EX slot
  bit                m_valid;
  rv32i_control_word m_cword;
  logic [31:0]       m_pc, m_d1, m_d2;
  logic [4:0]        m_rs1, m_rs2;
  rv32i_imm_bundle   m_imm;
  int                m_lu, m_fl;

  rv32i_opcode ops_list [9] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                                op_load, op_store, op_imm, op_reg};

  typedef struct {
    string             name;
    rv32i_control_word ex_cw;
    rv32i_control_word id_cw;
    logic              id_v;
    logic [4:0]        rs1, rs2;
    logic              fl;
    logic              exp_hold;
    logic              exp_valid;
    int                exp_lu;
    int                exp_fl;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rv32i_control_word mk(input rv32i_opcode op, input logic [4:0] rd,
                                           input logic lr, input logic mr, input logic mw);
    rv32i_control_word c;
    c = CWORD_NOP;
    c.opcode = op;
    c.rd = rd;
    c.load_regfile = lr;
    c.mem_read = mr;
    c.mem_write = mw;
    c.regfile_mux_sel = 4'h3;
    c.alu_mux2_sel = 3'h2;
    return c;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // which registers does the ID instruction actually read?
  function automatic bit model_hazard();
    logic [4:0] srcs[$];
    if (!(m_valid && m_cword.mem_read && m_cword.load_regfile && m_cword.rd != 5'd0 && id_valid))
      return 1'b0;
    case (id_cword.opcode)
      op_jalr, op_load, op_imm: srcs.push_back(id_rs1);
      op_br, op_store, op_reg: begin srcs.push_back(id_rs1); srcs.push_back(id_rs2); end
      default: ;
    endcase
    foreach (srcs[k]) if (srcs[k] == m_cword.rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_hold();
    return mem_stall || (model_hazard() && !flush);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cword = CWORD_NOP; m_pc = 0; m_d1 = 0; m_d2 = 0;
    m_rs1 = 0; m_rs2 = 0; m_imm = '0; m_lu = 0; m_fl = 0;
  endtask

  task automatic tick();
    bit lu;
    lu = model_hazard();
    if (!mem_stall) begin
      m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
      if (flush) begin
        m_valid = 0; m_cword = CWORD_NOP;
        if (id_valid) m_fl = sat(m_fl + 1);
      end else if (lu) begin
        m_valid = 0; m_cword = CWORD_NOP; m_lu = sat(m_lu + 1);
      end else begin
        m_valid = id_valid; m_cword = id_valid ? id_cword : CWORD_NOP;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ex_valid"}, ex_valid, m_valid);
    chk({tag, ".ex_cword"}, ex_cword, m_cword);
    if (m_valid) begin
      chk({tag, ".ex_pc"}, ex_pc, m_pc);
      chk({tag, ".ex_rs"}, {ex_rs1, ex_rs2}, {m_rs1, m_rs2});
      chk({tag, ".ex_data"}, {ex_rs1_data, ex_rs2_data}, {m_d1, m_d2});
      chk({tag, ".ex_imm"}, ex_imm, m_imm);
    end
    chk({tag, ".load_use_cnt"}, load_use_cnt, m_lu);
    chk({tag, ".flush_cnt"}, flush_cnt, m_fl);
  endtask

  task automatic present(input logic v, input rv32i_control_word c, input logic [31:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] d1, input logic [31:0] d2);
    id_valid = v; id_cword = c; id_pc = pc; id_rs1 = r1; id_rs2 = r2;
    id_rs1_data = d1; id_rs2_data = d2;
    id_imm = '{i: pc + 32'h11, s: pc + 32'h22, b: pc + 32'h33, u: pc + 32'h44, j: pc + 32'h55};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_stall = 0; flush = 0;
    present(1'b0, CWORD_NOP, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic add_vec(input string n, input rv32i_control_word e, input rv32i_control_word i,
                         input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic f,
                         input logic h, input logic ev, input int lu, input int fl);
    vec_t t;
    t.name = n; t.ex_cw = e; t.id_cw = i; t.id_v = v; t.rs1 = r1; t.rs2 = r2; t.fl = f;
    t.exp_hold = h; t.exp_valid = ev; t.exp_lu = lu; t.exp_fl = fl;
    vecs.push_back(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rv32i_control_word lw5, lw0, add6, addx5, sw0, lui5, br0, jal0, jalr0, imm0;
    lw5   = mk(op_load, 5'd5, 1, 1, 0);
    lw0   = mk(op_load, 5'd0, 1, 1, 0);
    add6  = mk(op_reg, 5'd6, 1, 0, 0);
    addx5 = mk(op_reg, 5'd5, 1, 0, 0);
    sw0   = mk(op_store, 5'd0, 0, 0, 1);
    lui5  = mk(op_lui, 5'd5, 1, 0, 0);
    br0   = mk(op_br, 5'd0, 0, 0, 0);
    jal0  = mk(op_jal, 5'd1, 1, 0, 0);
    jalr0 = mk(op_jalr, 5'd1, 1, 0, 0);
    imm0  = mk(op_imm, 5'd7, 1, 0, 0);

    //       name        EX     ID    idv rs1 rs2 fl hold valid lu fl
    add_vec("lu_rs2",    lw5,   add6,  1, 1, 5, 0, 1, 0, 1, 0);
    add_vec("lw_x0",     lw0,   add6,  1, 0, 0, 0, 0, 1, 0, 0);
    add_vec("lui_nouse", lw5,   lui5,  1, 5, 5, 0, 0, 1, 0, 0);
    add_vec("sw_rs1",    lw5,   sw0,   1, 5, 9, 0, 1, 0, 1, 0);
    add_vec("flush_lu",  lw5,   add6,  1, 1, 5, 1, 0, 0, 0, 1);
    add_vec("alu_nolu",  addx5, add6,  1, 5, 5, 0, 0, 1, 0, 0);
    add_vec("br_rs2",    lw5,   br0,   1, 3, 5, 0, 1, 0, 1, 0);
    add_vec("jal_nouse", lw5,   jal0,  1, 5, 5, 0, 0, 1, 0, 0);
    add_vec("id_inval",  lw5,   add6,  0, 1, 5, 0, 0, 0, 0, 0);
    add_vec("fl_inval",  lw5,   add6,  0, 1, 5, 1, 0, 0, 0, 0);
    add_vec("jalr_rs1",  lw5,   jalr0, 1, 5, 2, 0, 1, 0, 1, 0);
    add_vec("imm_rs2",   lw5,   imm0,  1, 1, 5, 0, 0, 1, 0, 0);

    // reset and first capture
    do_reset();
    chk("rst.ex_valid", ex_valid, 1'b0);
    chk("rst.ex_cword", ex_cword, CWORD_NOP);
    chk("rst.ex_pc", ex_pc, 32'h0);
    chk("rst.ex_data", {ex_rs1_data, ex_rs2_data}, 64'h0);
    chk("rst.ex_imm", ex_imm, 160'h0);
    chk("rst.cnts", {load_use_cnt, flush_cnt}, 4'h0);
    present(1'b1, mk(op_reg, 5'd3, 1, 0, 0), 32'h100, 5'd1, 5'd2, 32'd5, 32'd7);
    #1 chk("cap.hold", hold_if_id, 1'b0);
    tick();
    chk("cap.ex_valid", ex_valid, 1'b1);
    chk("cap.ex_data", {ex_rs1_data, ex_rs2_data}, {32'd5, 32'd7});
    chk("cap.cnts", {load_use_cnt, flush_cnt}, 4'h0);
    check_all("cap");

    // table of single-step hazard cases
    foreach (vecs[n]) begin
      do_reset();
      present(1'b1, vecs[n].ex_cw, 32'h400, 5'd0, 5'd0, 32'h1, 32'h2);
      tick();
      present(vecs[n].id_v, vecs[n].id_cw, 32'h404, vecs[n].rs1, vecs[n].rs2, 32'h3, 32'h4);
      flush = vecs[n].fl;
      #1 chk({vecs[n].name, ".hold"}, hold_if_id, vecs[n].exp_hold);
      tick();
      chk({vecs[n].name, ".ex_valid"}, ex_valid, vecs[n].exp_valid);
      chk({vecs[n].name, ".lu_cnt"}, load_use_cnt, vecs[n].exp_lu);
      chk({vecs[n].name, ".fl_cnt"}, flush_cnt, vecs[n].exp_fl);
      flush = 0;
    end

    // load-use: one bubble, then the re-presented add enters EX
    do_reset();
    present(1'b1, lw5, 32'h500, 5'd2, 5'd0, 32'h0, 32'h0);
    tick();
    present(1'b1, add6, 32'h504, 5'd1, 5'd5, 32'h9, 32'h8);
    #1 chk("lu.hold1", hold_if_id, 1'b1);
    tick();
    chk("lu.bubble", {ex_valid, load_use_cnt}, {1'b0, 2'd1});
    chk("lu.bubble_cword", ex_cword, CWORD_NOP);
    #1 chk("lu.hold2", hold_if_id, 1'b0);
    tick();
    chk("lu.add_valid", ex_valid, 1'b1);
    chk("lu.add_cword", ex_cword, add6);
    chk("lu.add_rs2", ex_rs2, 5'd5);

    // mem_stall freezes everything, even with flush asserted
    do_reset();
    present(1'b1, addx5, 32'h200, 5'd1, 5'd2, 32'hA, 32'hB);
    tick();
    mem_stall = 1; flush = 1;
    present(1'b1, lw5, 32'h300, 5'd3, 5'd4, 32'hC, 32'hD);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall.hold", hold_if_id, 1'b1);
      tick();
      chk("stall.ex", {ex_valid, ex_pc, ex_rs1_data}, {1'b1, 32'h200, 32'hA});
      chk("stall.cnts", {load_use_cnt, flush_cnt}, 4'h0);
    end
    mem_stall = 0;
    #1 chk("stall.rel_hold", hold_if_id, 1'b0);
    tick();
    chk("stall.rel", {ex_valid, flush_cnt}, {1'b0, 2'd1});
    check_all("stall");
    flush = 0;

    // saturation after four load-use events, then asynchronous reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      present(1'b1, lw5, 32'h600, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      present(1'b1, add6, 32'h604, 5'd5, 5'd1, 32'h0, 32'h0);
      tick();
    end
    chk("sat.lu_cnt", load_use_cnt, 2'd3);
    present(1'b1, lw5, 32'h700, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("sat.pre_rst", {ex_valid, ex_pc}, {1'b1, 32'h700});
    #2 rst = 1'b1;
    #1;
    chk("arst.ex", {ex_valid, ex_pc, load_use_cnt}, {1'b0, 32'h0, 2'd0});
    chk("arst.cword", ex_cword, CWORD_NOP);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    present(1'b1, add6, 32'h800, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    chk("arst.recap", {ex_valid, ex_pc}, {1'b1, 32'h800});

    // randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rv32i_control_word rc;
      rc = CWORD_NOP;
      rc.opcode = ops_list[$urandom_range(0, 8)];
      rc.aluop = alu_ops'(3'($urandom));
      rc.rd = 5'($urandom_range(0, 3));
      rc.load_regfile = 1'($urandom);
      rc.mem_read = 1'($urandom);
      rc.mem_write = 1'($urandom);
      rc.alu_mux2_sel = 3'($urandom);
      rc.mem_wmask = 4'($urandom);
      present(1'($urandom_range(0, 9) < 8), rc, $urandom, 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom, $urandom);
      mem_stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 19) < 3);
      #1 chk("rnd.hold", hold_if_id, model_hold());
      tick();
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
